// File: rtl/wshb_arbiter.sv
// -----------------------------------------------------------------------------
// wshb_arbiter
//   Two-master, one-slave Wishbone arbiter for the shared SDRAM port.
//   Master 0 is the display read path (frame-buffer fetch); master 1 is the
//   pattern/video write path. A grant is registered and held for the whole bus
//   cycle (mX_cyc high). Simultaneous requests are resolved round-robin. Each
//   grant has an ack budget: once MAX_ACKS acks have been forwarded and the
//   other master is waiting, the granted master sees an advisory yield.
//
// Configuration macro:
//   WSHB_ARB_FIXED_PRIO_EN  defined   -> master 0 always wins simultaneous
//                                        requests, m0_yield tied to 0.
//                           undefined -> round-robin (default build).
//
// Ports:
//   clk, rst                   system clock, synchronous active-high reset
//   m<i>_cyc/stb/we/adr/dat_ms/sel/cti/bte   master i request side (i = 0,1)
//   m<i>_ack                   ack to master i, only while master i is granted
//   m<i>_dat_sm                slave read data, broadcast to both masters
//   m<i>_yield                 advisory "end your cycle at a burst boundary"
//   s_cyc/stb/we/adr/dat_ms/sel/cti/bte      muxed request to the slave
//   s_ack, s_dat_sm            slave response
// -----------------------------------------------------------------------------
module wshb_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_ACKS = 64
) (
  input  logic            clk,
  input  logic            rst,
  // master 0
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_ms,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [2:0]      m0_cti,
  input  logic [1:0]      m0_bte,
  output logic            m0_ack,
  output logic [DW-1:0]   m0_dat_sm,
  output logic            m0_yield,
  // master 1
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_ms,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [2:0]      m1_cti,
  input  logic [1:0]      m1_bte,
  output logic            m1_ack,
  output logic [DW-1:0]   m1_dat_sm,
  output logic            m1_yield,
  // slave
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_ms,
  output logic [DW/8-1:0] s_sel,
  output logic [2:0]      s_cti,
  output logic [1:0]      s_bte,
  input  logic            s_ack,
  input  logic [DW-1:0]   s_dat_sm
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  // Counter is wide enough to hold MAX_ACKS itself; it saturates there.
  localparam int            CW      = $clog2(MAX_ACKS + 1);
  localparam logic [CW-1:0] ACK_MAX = CW'(MAX_ACKS);

  state_e        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] ack_cnt_q, ack_cnt_d;
  logic          pick1;
  logic          budget_spent;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    ack_cnt_d  = ack_cnt_q;
    pick1      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
`ifdef WSHB_ARB_FIXED_PRIO_EN
          pick1 = 1'b0;
`else
          pick1 = ~last_gnt_q;   // grant whoever did not have the bus last
`endif
        end else begin
          pick1 = m1_cyc;
        end
        if (m0_cyc || m1_cyc) begin
          state_d    = pick1 ? GNT1 : GNT0;
          last_gnt_d = pick1;
          ack_cnt_d  = '0;
        end
        // A spurious s_ack here is deliberately ignored.
      end
      GNT0, GNT1: begin
        if (s_ack && ack_cnt_q != ACK_MAX)
          ack_cnt_d = ack_cnt_q + CW'(1);
        // Always pass through IDLE so s_cyc drops between owners.
        if ((state_q == GNT0 && !m0_cyc) || (state_q == GNT1 && !m1_cyc))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      ack_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      ack_cnt_q  <= ack_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus mux: the registered grant selects which master drives the slave.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    unique case (state_q)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
      end
      default: ;
    endcase
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  // Yield is advisory: the granted master decides when to drop cyc.
  assign budget_spent = (ack_cnt_q >= ACK_MAX);
`ifdef WSHB_ARB_FIXED_PRIO_EN
  assign m0_yield = 1'b0;
`else
  assign m0_yield = (state_q == GNT0) && budget_spent && m1_cyc;
`endif
  assign m1_yield = (state_q == GNT1) && budget_spent && m0_cyc;

endmodule

// File: tb/tb_wshb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wshb_arbiter
//   Directed bench for wshb_arbiter (default parameters, round-robin build).
//   Inputs change 1 ns after the rising edge; outputs are checked 2 ns after
//   the rising edge, well clear of the active edge.
// -----------------------------------------------------------------------------
module tb_wshb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_ACKS = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            m0_cyc, m0_stb, m0_we;
  logic [AW-1:0]   m0_adr;
  logic [DW-1:0]   m0_dat_ms;
  logic [DW/8-1:0] m0_sel;
  logic [2:0]      m0_cti;
  logic [1:0]      m0_bte;
  logic            m0_ack, m0_yield;
  logic [DW-1:0]   m0_dat_sm;
  logic            m1_cyc, m1_stb, m1_we;
  logic [AW-1:0]   m1_adr;
  logic [DW-1:0]   m1_dat_ms;
  logic [DW/8-1:0] m1_sel;
  logic [2:0]      m1_cti;
  logic [1:0]      m1_bte;
  logic            m1_ack, m1_yield;
  logic [DW-1:0]   m1_dat_sm;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_ms;
  logic [DW/8-1:0] s_sel;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic            s_ack;
  logic [DW-1:0]   s_dat_sm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wshb_arbiter #(.AW(AW), .DW(DW), .MAX_ACKS(MAX_ACKS)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm), .m0_yield(m0_yield),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm), .m1_yield(m1_yield),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_dat_sm(s_dat_sm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge (input-drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before checking.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_ms = '0;
    m0_sel = '0; m0_cti = '0; m0_bte = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_ms = '0;
    m1_sel = '0; m1_cti = '0; m1_bte = '0;
    s_ack = 0; s_dat_sm = 32'hDEAD_BEEF;

    // ---- reset: two clocks of rst ----
    tick(); tick();
    settle();
    check("rst_s_cyc",    32'(s_cyc),    32'h0);
    check("rst_m0_ack",   32'(m0_ack),   32'h0);
    check("rst_m1_ack",   32'(m1_ack),   32'h0);
    check("rst_m0_yield", 32'(m0_yield), 32'h0);
    check("rst_m1_yield", 32'(m1_yield), 32'h0);
    check("rst_s_adr",    s_adr,         32'h0);
    check("dat_bcast0",   m0_dat_sm,     32'hDEAD_BEEF);
    check("dat_bcast1",   m1_dat_sm,     32'hDEAD_BEEF);

    // ---- master 1 alone: ten writes at 0x100..0x124 ----
    rst = 1'b0;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF; m1_cti = 3'd2; m1_bte = 2'd0;
    m1_adr = 32'h100; m1_dat_ms = 32'hA000_0000;
    settle();
    check("m1_lat_s_cyc0", 32'(s_cyc), 32'h0);   // grant not yet registered
    tick();
    settle();
    check("m1_gnt_s_cyc",  32'(s_cyc), 32'h1);
    check("m1_gnt_s_we",   32'(s_we),  32'h1);
    check("m1_gnt_s_sel",  32'(s_sel), 32'hF);
    check("m1_gnt_s_cti",  32'(s_cti), 32'h2);
    for (int k = 0; k < 10; k++) begin
      m1_adr    = 32'h100 + 32'(4 * k);
      m1_dat_ms = 32'hA000_0000 + 32'(k);
      s_ack     = 1'b1;
      settle();
      check("m1_wr_adr", s_adr,    32'h100 + 32'(4 * k));
      check("m1_wr_dat", s_dat_ms, 32'hA000_0000 + 32'(k));
      check("m1_wr_ack", 32'(m1_ack), 32'h1);
      check("m1_wr_m0_ack", 32'(m0_ack), 32'h0);
      tick();
    end
    s_ack = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    tick();
    settle();
    check("m1_done_s_cyc", 32'(s_cyc), 32'h0);

    // ---- spurious s_ack while idle ----
    s_ack = 1'b1;
    settle();
    check("spur_m0_ack", 32'(m0_ack), 32'h0);
    check("spur_m1_ack", 32'(m1_ack), 32'h0);
    check("spur_s_cyc",  32'(s_cyc),  32'h0);
    tick();
    s_ack = 1'b0;

    // ---- both request from reset: m0 first, IDLE gap, then m1 ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h200; m0_sel = 4'h3;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h300; m1_sel = 4'hF;
    tick();
    settle();
    check("both_gnt0_adr", s_adr,        32'h200);
    check("both_gnt0_cyc", 32'(s_cyc),   32'h1);
    check("both_gnt0_we",  32'(s_we),    32'h0);
    s_ack = 1'b1; s_dat_sm = 32'h1234_5678;
    settle();
    check("both_m0_ack",   32'(m0_ack),  32'h1);
    check("both_m1_ack",   32'(m1_ack),  32'h0);
    check("both_m0_rdat",  m0_dat_sm,    32'h1234_5678);
    tick();
    s_ack = 1'b0;
    m0_cyc = 0; m0_stb = 0;
    tick();
    settle();
    check("handover_idle_cyc", 32'(s_cyc), 32'h0);
    tick();
    settle();
    check("handover_gnt1_adr", s_adr,      32'h300);
    check("handover_gnt1_cyc", 32'(s_cyc), 32'h1);
    check("handover_m0_yield", 32'(m0_yield), 32'h0);

    // ---- ack budget: m1 holds the bus while m0 waits ----
    m0_cyc = 1; m0_stb = 1;
    for (int k = 0; k < MAX_ACKS; k++) begin
      s_ack = 1'b0;
      settle();
      check("budget_yield_low", 32'(m1_yield), 32'h0);
      s_ack = 1'b1;
      tick();
    end
    s_ack = 1'b0;
    settle();
    check("budget_m1_yield", 32'(m1_yield), 32'h1);
    check("budget_m0_yield", 32'(m0_yield), 32'h0);
    check("budget_still_m1", s_adr,         32'h300);
    // Extra acks: counter saturates, yield stays up.
    s_ack = 1'b1;
    tick(); tick();
    s_ack = 1'b0;
    settle();
    check("budget_sat_yield", 32'(m1_yield), 32'h1);
    m0_cyc = 0;
    settle();
    check("budget_no_waiter", 32'(m1_yield), 32'h0);
    m0_cyc = 1;
    m1_cyc = 0; m1_stb = 0;
    tick();
    settle();
    check("yield_idle_cyc", 32'(s_cyc), 32'h0);
    tick();
    settle();
    check("yield_gnt0_adr", s_adr,           32'h200);
    check("yield_gnt0_cyc", 32'(s_cyc),      32'h1);
    check("yield_gnt0_y0",  32'(m0_yield),   32'h0);

    // ---- reset in the middle of an m0 burst ----
    for (int k = 0; k < 5; k++) begin
      s_ack = 1'b1;
      settle();
      check("burst_m0_ack", 32'(m0_ack), 32'h1);
      tick();
    end
    rst = 1'b1;          // slave keeps acking across the reset edge
    tick();
    settle();
    check("midrst_s_cyc",  32'(s_cyc),  32'h0);
    check("midrst_m0_ack", 32'(m0_ack), 32'h0);
    check("midrst_m1_ack", 32'(m1_ack), 32'h0);
    rst = 1'b0;
    s_ack = 1'b0;
    tick();
    settle();
    check("postrst_regrant", 32'(s_cyc), 32'h1);
    check("postrst_adr",     s_adr,      32'h200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
